// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver: two-flop synchroniser, 3-sample majority vote,
// mid-bit sampling, one-cycle valid / frame_err strobes and break absorption.
module uart_rx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t state_reg, state_next;

   logic              rx_meta_reg;
   logic              rx_s_reg;
   logic [2:0]        hist_reg;
   logic              vote;

   logic [TICK_W-1:0] tick_reg, tick_next;
   logic [2:0]        bit_reg, bit_next;
   logic [7:0]        shift_reg, shift_next;
   logic [7:0]        data_reg, data_next;
   logic              valid_reg, valid_next;
   logic              frame_err_reg, frame_err_next;

   // Idle-high reset values keep a reset release from looking like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_reg <= 1'b1;
         rx_s_reg    <= 1'b1;
         hist_reg    <= 3'b111;
      end else begin
         rx_meta_reg <= RX;
         rx_s_reg    <= rx_meta_reg;
         hist_reg    <= {hist_reg[1:0], rx_s_reg};
      end
   end

   assign vote = (hist_reg[0] & hist_reg[1]) |
                 (hist_reg[1] & hist_reg[2]) |
                 (hist_reg[0] & hist_reg[2]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (!rx_s_reg) begin
               state_next = S_START;
            end
         end
         S_START: begin
            if (tick_reg == TICK_HALF) begin
               state_next = vote ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (tick_reg == TICK_LAST && bit_reg == 3'd7) begin
               state_next = S_STOP;
            end
         end
         S_STOP: begin
            if (tick_reg == TICK_LAST) begin
               state_next = vote ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            if (rx_s_reg) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      tick_next      = tick_reg;
      bit_next       = bit_reg;
      shift_next     = shift_reg;
      data_next      = data_reg;
      valid_next     = 1'b0;
      frame_err_next = 1'b0;
      case (state_reg)
         S_IDLE: begin
            tick_next = '0;
            bit_next  = '0;
         end
         S_START: begin
            if (tick_reg == TICK_HALF) begin
               tick_next = '0;
               bit_next  = '0;
            end else begin
               tick_next = tick_reg + TICK_W'(1);
            end
         end
         S_DATA: begin
            // LSB arrives first, so each new bit enters at the top and walks down.
            if (tick_reg == TICK_LAST) begin
               shift_next = {vote, shift_reg[7:1]};
               tick_next  = '0;
               bit_next   = bit_reg + 3'd1;
            end else begin
               tick_next = tick_reg + TICK_W'(1);
            end
         end
         S_STOP: begin
            if (tick_reg == TICK_LAST) begin
               tick_next = '0;
               if (vote) begin
                  data_next  = shift_reg;
                  valid_next = 1'b1;
               end else begin
                  frame_err_next = 1'b1;
               end
            end else begin
               tick_next = tick_reg + TICK_W'(1);
            end
         end
         default: begin
            tick_next = '0;
            bit_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_reg      <= '0;
         bit_reg       <= '0;
         shift_reg     <= '0;
         data_reg      <= '0;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         tick_reg      <= tick_next;
         bit_reg       <= bit_next;
         shift_reg     <= shift_next;
         data_reg      <= data_next;
         valid_reg     <= valid_next;
         frame_err_reg <= frame_err_next;
      end
   end

   assign busy      = (state_reg != S_IDLE);
   assign data      = data_reg;
   assign valid     = valid_reg;
   assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OVERSAMPLE=16: good frames, back-to-back, glitch,
// framing error with break, mid-frame reset, and noisy / slow-baud frame.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_line = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   int         cyc = 0;
   int         valid_cnt = 0;
   int         ferr_cnt = 0;
   int         both_cnt = 0;
   int         v_cyc[$];
   logic [7:0] v_data[$];
   int         fe_cyc_last = -1;
   int         busy_rise = -1;
   int         busy_fall = -1;
   logic       busy_q = 1'b0;

   uart_rx #(.OVERSAMPLE(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .RX        (rx_line),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder, sampled mid-cycle.
   always @(negedge clk) begin
      if (valid) begin
         valid_cnt <= valid_cnt + 1;
         v_cyc.push_back(cyc);
         v_data.push_back(data);
         $display("rx byte %02h at cycle %0d", data, cyc);
      end
      if (frame_err) begin
         ferr_cnt    <= ferr_cnt + 1;
         fe_cyc_last <= cyc;
         $display("rx framing error at cycle %0d", cyc);
      end
      if (valid && frame_err) both_cnt <= both_cnt + 1;
      if (busy && !busy_q) busy_rise <= cyc;
      if (!busy && busy_q) busy_fall <= cyc;
      busy_q <= busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Optional spikes: one-clock low pulse 4 clocks into every high data bit.
   task automatic send_byte(input logic [7:0] b, input int period, input bit stop_bit, input bit spikes);
      rx_line = 1'b0;
      wait_clk(period);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         if (spikes && b[i]) begin
            wait_clk(4);
            rx_line = 1'b0;
            wait_clk(1);
            rx_line = 1'b1;
            wait_clk(period - 5);
         end else begin
            wait_clk(period);
         end
      end
      rx_line = stop_bit;
      wait_clk(period);
   endtask

   int s;
   int r;
   int vbase;
   int fbase;

   initial begin
      // Reset state
      wait_clk(3);
      check("reset_data", 32'(data), 32'h00);
      check("reset_valid", 32'(valid), 0);
      check("reset_frame_err", 32'(frame_err), 0);
      check("reset_busy", 32'(busy), 0);
      rst = 1'b0;
      wait_clk(20);
      check("idle_busy", 32'(busy), 0);

      // Single frame 0xA5: E0 = s+3, stop sample at E0+152
      vbase = valid_cnt;
      fbase = ferr_cnt;
      s = cyc;
      send_byte(8'hA5, 16, 1'b1, 1'b0);
      wait_clk(20);
      check("a5_valid_count", valid_cnt - vbase, 1);
      check("a5_valid_cycle", v_cyc[vbase], s + 155);
      check("a5_valid_data", 32'(v_data[vbase]), 32'hA5);
      check("a5_data_held", 32'(data), 32'hA5);
      check("a5_no_frame_err", ferr_cnt - fbase, 0);
      check("a5_busy_rise", 32'(busy_rise == s + 3 || busy_rise == s + 4), 1);
      check("a5_busy_fall", busy_fall, s + 155);

      // Back-to-back 00, FF, 5A with no idle gap
      vbase = valid_cnt;
      s = cyc;
      send_byte(8'h00, 16, 1'b1, 1'b0);
      send_byte(8'hFF, 16, 1'b1, 1'b0);
      send_byte(8'h5A, 16, 1'b1, 1'b0);
      wait_clk(20);
      check("b2b_valid_count", valid_cnt - vbase, 3);
      check("b2b_cycle0", v_cyc[vbase], s + 155);
      check("b2b_cycle1", v_cyc[vbase + 1], s + 315);
      check("b2b_cycle2", v_cyc[vbase + 2], s + 475);
      check("b2b_data0", 32'(v_data[vbase]), 32'h00);
      check("b2b_data1", 32'(v_data[vbase + 1]), 32'hFF);
      check("b2b_data2", 32'(v_data[vbase + 2]), 32'h5A);

      // Start glitch: 4-clock low pulse, back to IDLE at E0+8
      vbase = valid_cnt;
      fbase = ferr_cnt;
      s = cyc;
      rx_line = 1'b0;
      wait_clk(4);
      rx_line = 1'b1;
      wait_clk(30);
      check("glitch_busy_rise", 32'(busy_rise == s + 3 || busy_rise == s + 4), 1);
      check("glitch_busy_fall", busy_fall, s + 11);
      check("glitch_no_valid", valid_cnt - vbase, 0);
      check("glitch_no_frame_err", ferr_cnt - fbase, 0);
      check("glitch_data", 32'(data), 32'h5A);

      // Framing error: 0x3C with low stop bit, then 500 clocks of break
      vbase = valid_cnt;
      fbase = ferr_cnt;
      s = cyc;
      send_byte(8'h3C, 16, 1'b0, 1'b0);
      wait_clk(500);
      check("break_busy_held", 32'(busy), 1);
      check("break_frame_err_count", ferr_cnt - fbase, 1);
      check("break_frame_err_cycle", fe_cyc_last, s + 155);
      r = cyc;
      rx_line = 1'b1;
      wait_clk(20);
      check("break_busy_fall", busy_fall, r + 3);
      check("break_no_valid", valid_cnt - vbase, 0);
      check("break_data_kept", 32'(data), 32'h5A);
      check("break_single_frame_err", ferr_cnt - fbase, 1);

      vbase = valid_cnt;
      s = cyc;
      send_byte(8'h11, 16, 1'b1, 1'b0);
      wait_clk(20);
      check("post_break_valid_count", valid_cnt - vbase, 1);
      check("post_break_valid_cycle", v_cyc[vbase], s + 155);
      check("post_break_data", 32'(data), 32'h11);

      // Reset during bit 4 of 0xC3
      vbase = valid_cnt;
      rx_line = 1'b0;
      wait_clk(16);
      for (int i = 0; i < 4; i++) begin
         rx_line = 8'hC3 >> i;
         wait_clk(16);
      end
      rx_line = 1'b0;
      wait_clk(8);
      check("midframe_busy_before_rst", 32'(busy), 1);
      rst = 1'b1;
      #1;
      check("midrst_data", 32'(data), 32'h00);
      check("midrst_valid", 32'(valid), 0);
      check("midrst_frame_err", 32'(frame_err), 0);
      check("midrst_busy", 32'(busy), 0);
      rx_line = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(200);
      check("midrst_no_valid", valid_cnt - vbase, 0);
      check("midrst_busy_idle", 32'(busy), 0);
      s = cyc;
      send_byte(8'h7E, 16, 1'b1, 1'b0);
      wait_clk(20);
      check("after_rst_valid_count", valid_cnt - vbase, 1);
      check("after_rst_valid_cycle", v_cyc[vbase], s + 155);
      check("after_rst_data", 32'(data), 32'h7E);

      // Noise spikes and 17-clock bits
      vbase = valid_cnt;
      fbase = ferr_cnt;
      s = cyc;
      send_byte(8'hFF, 17, 1'b1, 1'b1);
      wait_clk(20);
      check("noise_valid_count", valid_cnt - vbase, 1);
      check("noise_valid_cycle", v_cyc[vbase], s + 155);
      check("noise_data", 32'(data), 32'hFF);
      check("noise_no_frame_err", ferr_cnt - fbase, 0);

      check("valid_and_frame_err_never_together", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
